// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver: frame FSM states, prefix bytes and FIFO entry layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key-event read port: valid/ready handshake plus the decoded head event.
interface ps2_keyboard_rx_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic [7:0] ev_ascii;

    modport master (
        output ev_valid, ev_code, ev_break, ev_ext, ev_ascii,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_code, ev_break, ev_ext, ev_ascii,
        output ev_ready
    );

endinterface

// File: rtl/ps2_scan_ascii.sv
// Scan code set 2 to lowercase ASCII; letters, digits, space and enter, 8'h00 otherwise.
module ps2_scan_ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM with watchdog, make/break/extended assembly, event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the held key.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps2_clk,
    input  logic                    ps2_dat,
    ps2_keyboard_rx_if.master       ev,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int WD_LIMIT = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    // Synchronizers reset to the idle-high line level so reset release never looks like a fall.
    logic [2:0] ps2c_sync_q, ps2c_sync_d;
    logic [2:0] ps2d_sync_q, ps2d_sync_d;
    logic       fall;
    logic       dat;

    assign ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
    assign ps2d_sync_d = {ps2d_sync_q[1:0], ps2_dat};
    assign fall        = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    assign dat         = ps2d_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_sync_q <= 3'b111;
            ps2d_sync_q <= 3'b111;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
        end
    end

    ps2_state_e       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             byte_vld_q, byte_vld_d;
    logic [7:0]       byte_q, byte_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;
        wd_d        = (state_q == ST_IDLE || fall) ? '0 : wd_q + 1'b1;
        timeout     = (state_q != ST_IDLE) && !fall && (wd_q == WD_W'(WD_LIMIT - 1));

        if (timeout) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            wd_d        = '0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {dat, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat && (^{shreg_q, par_q})) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shreg_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    // Byte layer: prefixes only arm flags; the next ordinary byte carries them into the FIFO.
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       push;
    ps2_event_t push_entry;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_vld_q, held_vld_d;
    logic [8:0] held_q, held_d;
`endif

    always_comb begin
        ext_pend_d      = ext_pend_q;
        brk_pend_d      = brk_pend_q;
        push            = 1'b0;
        push_entry.ext  = ext_pend_q;
        push_entry.brk  = brk_pend_q;
        push_entry.code = byte_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_vld_d = held_vld_q;
        held_d     = held_q;
`endif
        if (frame_err_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == PS2_BREAK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                push       = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (brk_pend_q) begin
                    held_vld_d = 1'b0;
                end else if (held_vld_q && (held_q == {ext_pend_q, byte_q})) begin
                    push = 1'b0;
                end else begin
                    held_vld_d = 1'b1;
                    held_d     = {ext_pend_q, byte_q};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_vld_q <= 1'b0;
            held_q     <= '0;
`endif
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_vld_q <= held_vld_d;
            held_q     <= held_d;
`endif
        end
    end

    // Event FIFO, first-word fall-through; one extra pointer bit separates full from empty.
    ps2_event_t    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, pop, wr_en;
    ps2_event_t    head;
    logic [7:0]    map_ascii;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ev.ev_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    ps2_scan_ascii u_ascii (
        .code  (head.code),
        .ascii (map_ascii)
    );

    // Outputs are forced to zero while empty so the uninitialised storage never leaks out.
    assign ev.ev_valid = !empty;
    assign ev.ev_code  = empty ? 8'h00 : head.code;
    assign ev.ev_break = !empty && head.brk;
    assign ev.ev_ext   = !empty && head.ext;
    assign ev.ev_ascii = (empty || head.ext || head.brk) ? 8'h00 : map_ascii;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: PS/2 frames are driven bit by bit, a monitor pops on each handshake.
module tb_ps2_keyboard_rx;

    localparam int HALF       = 20;
    localparam int CLK_HZ     = 1000000;
    localparam int TIMEOUT_US = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic frame_err, overflow;

    ps2_keyboard_rx_if ev_if ();

    ps2_keyboard_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ev        (ev_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          err_cycles = 0;
    logic [17:0] exp_q[$];

    function automatic logic [17:0] mk(input bit x, input bit b, input logic [7:0] c, input logic [7:0] a);
        return {x, b, c, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [17:0] act;
        if (frame_err) err_cycles++;
        if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
            act = {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code, ev_if.ev_ascii};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_event: got %h, expected no event", act);
            end else begin
                chk("event", {14'd0, act}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #(900000 * 10);
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e0;
        ev_if.ev_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, ev_if.ev_valid, ev_if.ev_break, ev_if.ev_ext, frame_err, overflow, 1'b0},
            32'd0);
        chk("reset_code_ascii", {16'd0, ev_if.ev_code, ev_if.ev_ascii}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Held head before the pop, then handshake empties the FIFO.
        send_frame(8'h1C, 1'b0);
        chk("first_valid", {31'd0, ev_if.ev_valid}, 32'd1);
        chk("first_head", {14'd0, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code, ev_if.ev_ascii},
            {14'd0, mk(0, 0, 8'h1C, 8'h61)});
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
        @(posedge clk); #1 ev_if.ev_ready = 1'b1;
        @(posedge clk); #1 ev_if.ev_ready = 1'b0;
        @(negedge clk);
        chk("pop_empties", {31'd0, ev_if.ev_valid}, 32'd0);
        #1 ev_if.ev_ready = 1'b1;

        exp_q.push_back(mk(0, 1, 8'h1C, 8'h00));
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        exp_q.push_back(mk(1, 1, 8'h75, 8'h00));
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);

        e0 = err_cycles;
        send_frame(8'h32, 1'b1);
        chk("parity_err_pulse", err_cycles, e0 + 1);
        exp_q.push_back(mk(0, 0, 8'h21, 8'h63));
        send_frame(8'h21, 1'b0);

        // Frame abandoned after four data bits: the watchdog must fire once.
        e0 = err_cycles;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_dat = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("timeout_err_pulse", err_cycles, e0 + 1);
        exp_q.push_back(mk(0, 0, 8'h29, 8'h20));
        send_frame(8'h29, 1'b0);
        exp_q.push_back(mk(0, 0, 8'h5A, 8'h0D));
        send_frame(8'h5A, 1'b0);
        exp_q.push_back(mk(0, 0, 8'h45, 8'h30));
        send_frame(8'h45, 1'b0);
        exp_q.push_back(mk(1, 0, 8'h1C, 8'h00));
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);

        // A frame error between F0 and the key byte must drop the break flag.
        e0 = err_cycles;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h44, 1'b1);
        chk("prefix_err_pulse", err_cycles, e0 + 1);
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
        send_frame(8'h1C, 1'b0);
        chk("no_overflow_yet", {31'd0, overflow}, 32'd0);

        ev_if.ev_ready = 1'b0;
        exp_q.push_back(mk(0, 0, 8'h15, 8'h71));
        exp_q.push_back(mk(0, 0, 8'h1D, 8'h77));
        exp_q.push_back(mk(0, 0, 8'h24, 8'h65));
        exp_q.push_back(mk(0, 0, 8'h2D, 8'h72));
        exp_q.push_back(mk(0, 0, 8'h2C, 8'h74));
        exp_q.push_back(mk(0, 0, 8'h35, 8'h79));
        exp_q.push_back(mk(0, 0, 8'h3C, 8'h75));
        exp_q.push_back(mk(0, 0, 8'h43, 8'h69));
        send_frame(8'h15, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h24, 1'b0);
        send_frame(8'h2D, 1'b0);
        send_frame(8'h2C, 1'b0);
        send_frame(8'h35, 1'b0);
        send_frame(8'h3C, 1'b0);
        send_frame(8'h43, 1'b0);
        chk("full_no_overflow", {31'd0, overflow}, 32'd0);
        send_frame(8'h44, 1'b0);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        chk("full_head_stable", {16'd0, ev_if.ev_code, ev_if.ev_ascii}, {16'd0, 8'h15, 8'h71});
        ev_if.ev_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drained_after_overflow", {31'd0, ev_if.ev_valid}, 32'd0);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-frame: no error pulse, sticky flag cleared, receiver ready for a fresh frame.
        e0 = err_cycles;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("reset_midframe_no_err", err_cycles, e0);
        chk("reset_clears_overflow", {30'd0, overflow, ev_if.ev_valid}, 32'd0);
        exp_q.push_back(mk(0, 0, 8'h1B, 8'h73));
        send_frame(8'h1B, 1'b0);

`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
`else
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
        exp_q.push_back(mk(0, 0, 8'h1C, 8'h61));
`endif
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_empty", {31'd0, ev_if.ev_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
